// File: rtl/o_ddr_pkg.sv
// Shared constants and sizing helpers for the DDR output gearbox.
package o_ddr_pkg;

    localparam logic [1:0] DDR_IDLE_DEFAULT = 2'b00;

    function automatic int pairs(input int width);
        return width / 2;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 1);
    endfunction

endpackage

// File: rtl/o_ddr_gearbox.sv
// Parallel-to-pair gearbox feeding a DDR output register, LSB pair first.
module o_ddr_gearbox
    import o_ddr_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter logic [1:0] IDLE  = DDR_IDLE_DEFAULT
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output logic [1:0]       Q,
    output logic             Q_VALID
);

    localparam int PAIRS = pairs(WIDTH);
    localparam int CW    = cnt_width(WIDTH);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("o_ddr_gearbox: WIDTH must be even and within 4..32");
        end
    endgenerate

    logic [WIDTH-1:0] nr;
    logic             nr_full;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             load;

    // Ready depends only on registered state so upstream sees no loop.
    assign DATA_READY = R & ~nr_full;
    assign accept     = DATA_VALID & DATA_READY;
    // Reloading while one pair remains keeps the stream gapless.
    assign load       = E & nr_full & (cnt <= CW'(1));

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            nr      <= '0;
            nr_full <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            Q       <= 2'b00;
            Q_VALID <= 1'b0;
        end else begin
            if (accept) begin
                nr      <= DATA_IN;
                nr_full <= 1'b1;
            end
            if (E) begin
                if (cnt != '0) begin
                    Q       <= sr[1:0];
                    Q_VALID <= 1'b1;
                    sr      <= sr >> 2;
                    cnt     <= cnt - CW'(1);
                end else begin
                    Q       <= IDLE;
                    Q_VALID <= 1'b0;
                end
            end
            if (load) begin
                sr      <= nr;
                cnt     <= CW'(PAIRS);
                nr_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_o_ddr_gearbox.sv
// Bench for o_ddr_gearbox: directed vector table, corner sequences, random run.
module tb_o_ddr_gearbox;

    localparam int W = 8;
    localparam int P = W / 2;

    logic         C = 1'b0;
    logic         R = 1'b0;
    logic         E = 1'b0;
    logic [W-1:0] DATA_IN = '0;
    logic         DATA_VALID = 1'b0;
    logic         DATA_READY;
    logic [1:0]   Q;
    logic         Q_VALID;

    o_ddr_gearbox #(.WIDTH(W), .IDLE(2'b00)) dut (
        .C(C),
        .R(R),
        .E(E),
        .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .Q(Q),
        .Q_VALID(Q_VALID)
    );

    always #5 C = ~C;

    int total = 0;
    int bad   = 0;

    // Reference: queue of pairs still to emit plus a one-word holding slot.
    logic [1:0]   mq[$];
    logic [W-1:0] m_nr;
    bit           m_full;
    logic [1:0]   m_q;
    bit           m_v;

    typedef struct {
        bit           e;
        bit           dv;
        logic [W-1:0] d;
        logic [1:0]   q;
        bit           v;
        bit           rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_full = 1'b0;
        m_nr   = '0;
        m_q    = 2'b00;
        m_v    = 1'b0;
    endtask

    task automatic tick(input bit e, input bit dv, input logic [W-1:0] d);
        bit acc;
        int n;
        E          = e;
        DATA_VALID = dv;
        DATA_IN    = d;
        @(posedge C);
        acc = dv && !m_full;
        if (e) begin
            n = mq.size();
            if (n > 0) begin
                m_q = mq.pop_front();
                m_v = 1'b1;
            end else begin
                m_q = 2'b00;
                m_v = 1'b0;
            end
            if (m_full && n <= 1) begin
                for (int i = 0; i < P; i++) mq.push_back(m_nr[2*i +: 2]);
                m_full = 1'b0;
            end
        end
        if (acc) begin
            m_nr   = d;
            m_full = 1'b1;
        end
        #1;
        chk("q", 32'(Q), 32'(m_q));
        chk("q_valid", 32'(Q_VALID), 32'(m_v));
        chk("ready", 32'(DATA_READY), 32'(!m_full));
    endtask

    task automatic add(input bit e, input bit dv, input logic [W-1:0] d,
                       input logic [1:0] q, input bit v, input bit rdy);
        vec_t t;
        t.e = e; t.dv = dv; t.d = d; t.q = q; t.v = v; t.rdy = rdy;
        tbl.push_back(t);
    endtask

    initial begin
        bit           rdv;
        logic [W-1:0] rd;

        // single word B4
        add(1, 1, 8'hB4, 2'b00, 0, 0);
        add(1, 0, 8'h00, 2'b00, 0, 1);
        add(1, 0, 8'h00, 2'b00, 1, 1);
        add(1, 0, 8'h00, 2'b01, 1, 1);
        add(1, 0, 8'h00, 2'b11, 1, 1);
        add(1, 0, 8'h00, 2'b10, 1, 1);
        add(1, 0, 8'h00, 2'b00, 0, 1);
        // back-to-back B4 then 1E
        add(1, 1, 8'hB4, 2'b00, 0, 0);
        add(1, 0, 8'h00, 2'b00, 0, 1);
        add(1, 1, 8'h1E, 2'b00, 1, 0);
        add(1, 0, 8'h00, 2'b01, 1, 0);
        add(1, 0, 8'h00, 2'b11, 1, 0);
        add(1, 0, 8'h00, 2'b10, 1, 1);
        add(1, 0, 8'h00, 2'b10, 1, 1);
        add(1, 0, 8'h00, 2'b11, 1, 1);
        add(1, 0, 8'h00, 2'b01, 1, 1);
        add(1, 0, 8'h00, 2'b00, 1, 1);
        add(1, 0, 8'h00, 2'b00, 0, 1);

        // reset held with valid asserted
        model_reset();
        R = 1'b0; DATA_VALID = 1'b1; DATA_IN = 8'h77; E = 1'b1;
        repeat (3) @(posedge C);
        #1;
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_qv", 32'(Q_VALID), 32'h0);
        chk("rst_ready", 32'(DATA_READY), 32'h0);
        DATA_VALID = 1'b0;
        R = 1'b1;
        #1;
        chk("rel_ready", 32'(DATA_READY), 32'h1);
        chk("rel_qv", 32'(Q_VALID), 32'h0);

        foreach (tbl[i]) begin
            tick(tbl[i].e, tbl[i].dv, tbl[i].d);
            chk($sformatf("vec%0d_q", i), 32'(Q), 32'(tbl[i].q));
            chk($sformatf("vec%0d_v", i), 32'(Q_VALID), 32'(tbl[i].v));
            chk($sformatf("vec%0d_rdy", i), 32'(DATA_READY), 32'(tbl[i].rdy));
        end

        // enable freeze after the second pair
        tick(1, 1, 8'hB4);
        tick(1, 0, 8'h00);
        tick(1, 0, 8'h00);
        tick(1, 0, 8'h00);
        chk("frz_pre", 32'(Q), 32'h1);
        repeat (3) begin
            tick(0, 0, 8'h00);
            chk("frz_hold", 32'(Q), 32'h1);
            chk("frz_hold_v", 32'(Q_VALID), 32'h1);
        end
        tick(1, 0, 8'h00);
        chk("frz_res0", 32'(Q), 32'h3);
        tick(1, 0, 8'h00);
        chk("frz_res1", 32'(Q), 32'h2);
        tick(1, 0, 8'h00);
        chk("frz_end", 32'(Q_VALID), 32'h0);

        // reset mid-word with FF waiting in the holding register
        tick(1, 1, 8'h1E);
        tick(1, 0, 8'h00);
        tick(1, 1, 8'hFF);
        tick(1, 0, 8'h00);
        tick(1, 0, 8'h00);
        chk("mid_pair3", 32'(Q), 32'h1);
        chk("mid_full", 32'(DATA_READY), 32'h0);
        R = 1'b0;
        #1;
        chk("async_q", 32'(Q), 32'h0);
        chk("async_qv", 32'(Q_VALID), 32'h0);
        chk("async_ready", 32'(DATA_READY), 32'h0);
        @(posedge C);
        #1;
        R = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(DATA_READY), 32'h1);
        model_reset();
        repeat (6) begin
            tick(1, 0, 8'h00);
            chk("post_rst_idle", 32'(Q_VALID), 32'h0);
        end

        // backpressure: A5 waits behind 1E
        tick(1, 1, 8'hB4);
        tick(1, 0, 8'h00);
        tick(1, 1, 8'h1E);
        tick(1, 1, 8'hA5);
        chk("bp_ready", 32'(DATA_READY), 32'h0);
        tick(1, 1, 8'hA5);
        tick(1, 1, 8'hA5);
        chk("bp_reload_ready", 32'(DATA_READY), 32'h1);
        tick(1, 1, 8'hA5);
        chk("bp_accept", 32'(DATA_READY), 32'h0);
        repeat (3) tick(1, 0, 8'h00);
        chk("bp_1e_last", 32'(Q), 32'h0);
        tick(1, 0, 8'h00);
        chk("bp_a5_0", 32'(Q), 32'h1);
        chk("bp_a5_0v", 32'(Q_VALID), 32'h1);
        tick(1, 0, 8'h00);
        chk("bp_a5_1", 32'(Q), 32'h1);
        tick(1, 0, 8'h00);
        chk("bp_a5_2", 32'(Q), 32'h2);
        tick(1, 0, 8'h00);
        chk("bp_a5_3", 32'(Q), 32'h2);
        tick(1, 0, 8'h00);
        chk("bp_drain", 32'(Q_VALID), 32'h0);

        // random traffic, inputs held while stalled
        rdv = 1'b0;
        rd  = '0;
        for (int i = 0; i < 600; i++) begin
            if (!(rdv && m_full)) begin
                rdv = ($urandom_range(0, 3) != 0);
                rd  = W'($urandom);
            end
            tick($urandom_range(0, 4) != 0, rdv, rd);
        end
        repeat (12) tick(1, 0, 8'h00);
        chk("final_idle", 32'(Q_VALID), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
